// File: rtl/gate_response_checker_pkg.sv
// Shared definitions for the gate response checker: FSM state encoding, common
// 2-input truth tables (bit i = expected Y for stim==i) and a counter sizing helper.
package gate_response_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [3:0] TRUTH_AND2  = 4'b1000;
   localparam logic [3:0] TRUTH_OR2   = 4'b1110;
   localparam logic [3:0] TRUTH_XOR2  = 4'b0110;
   localparam logic [3:0] TRUTH_NAND2 = 4'b0111;

   function automatic int timer_width(input int settle);
      return (settle > 1) ? $clog2(settle) : 1;
   endfunction

endpackage

// File: rtl/gate_response_checker_settle_timer.sv
// Settle timer: load clears the count, expired_o is high on the last of SETTLE enabled cycles.
// Latency: expires SETTLE-1 cycles after load; no flow control, the count holds once expired.
module settle_timer
   import gate_response_checker_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = timer_width(SETTLE);
   localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired_o = en_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps every input vector onto a gate, samples its output after SETTLE cycles and scores it
// against TRUTH. Latency: done 1 + 2^N_IN*(SETTLE+1) cycles after start; start ignored while busy.
module gate_response_checker
   import gate_response_checker_pkg::*;
#(
   parameter int                      N_IN   = 2,
   parameter logic [(1<<N_IN)-1:0]    TRUTH  = TRUTH_AND2,
   parameter int                      SETTLE = 2,
   parameter int                      ERRW   = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] stim,
   input  logic            dut_y,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [ERRW-1:0] err_cnt,
   output logic            first_err_valid,
   output logic [N_IN-1:0] first_err_idx
);

   localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};
   localparam logic [ERRW-1:0] ERR_MAX   = {ERRW{1'b1}};

   state_e          state_q, state_d;
   logic [N_IN-1:0] stim_q, stim_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [ERRW-1:0] err_q, err_d;
   logic            fev_q, fev_d;
   logic [N_IN-1:0] fei_q, fei_d;
   logic            tmr_load;
   logic            tmr_expired;
   logic            mismatch;

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (tmr_load),
      .en_i      (state_q == ST_DRIVE),
      .expired_o (tmr_expired)
   );

   always_comb begin
      state_d  = state_q;
      stim_d   = stim_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_d    = err_q;
      fev_d    = fev_q;
      fei_d    = fei_q;
      tmr_load = 1'b0;
      mismatch = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_DRIVE;
               stim_d   = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               err_d    = '0;
               fev_d    = 1'b0;
               fei_d    = '0;
               tmr_load = 1'b1;
            end
         end

         ST_DRIVE: begin
            if (tmr_expired) begin
               state_d = ST_SAMPLE;
            end
         end

         ST_SAMPLE: begin
            mismatch = (dut_y != TRUTH[stim_q]);
            if (mismatch) begin
               if (err_q != ERR_MAX) begin
                  err_d = err_q + 1'b1;
               end
               if (!fev_q) begin
                  fev_d = 1'b1;
                  fei_d = stim_q;
               end
            end
            // Terminal check before increment so stim never wraps inside a run.
            if (stim_q == STIM_LAST) begin
               state_d = ST_DONE;
               stim_d  = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               state_d  = ST_DRIVE;
               stim_d   = stim_q + 1'b1;
               tmr_load = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         stim_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fev_q   <= 1'b0;
         fei_q   <= '0;
      end else begin
         state_q <= state_d;
         stim_q  <= stim_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fev_q   <= fev_d;
         fei_q   <= fei_d;
      end
   end

   assign stim            = stim_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_cnt         = err_q;
   assign first_err_valid = fev_q;
   assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: a configurable gate model (response table plus optional
// glitches while vectors settle) scored against a table-counting reference model.
module tb_gate_response_checker;
   import gate_response_checker_pkg::*;

   localparam int         N_IN   = 2;
   localparam int         SETTLE = 2;
   localparam logic [3:0] TRUTH  = TRUTH_AND2;
   localparam int         NV     = 1 << N_IN;
   localparam int         SWEEP  = 1 + NV * (SETTLE + 1);
   localparam int         BUDGET = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] stim;
   logic       dut_y;
   logic       busy, done, pass, fev;
   logic [7:0] err_cnt;
   logic [1:0] fei;

   logic       dut_y2;
   logic [1:0] stim2;
   logic       busy2, done2, pass2, fev2;
   logic [0:0] err2;
   logic [1:0] fei2;

   logic [3:0] resp_cur = TRUTH_AND2;
   logic       glitch_now = 1'b0;
   logic       glitch_val = 1'b0;

   int         n_cmp = 0;
   int         n_bad = 0;

   logic       obs_busy [0:63];
   logic [1:0] obs_stim [0:63];
   logic [7:0] obs_err  [0:63];
   logic       obs_done [0:63];
   int         done_at;

   // Gate under test: table lookup on the vector currently driven, optionally glitching.
   assign dut_y  = glitch_now ? glitch_val : resp_cur[stim];
   assign dut_y2 = ~(stim2[1] & stim2[0]);

   always #5 clk = ~clk;

   gate_response_checker #(.N_IN(N_IN), .TRUTH(TRUTH), .SETTLE(SETTLE), .ERRW(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_y(dut_y),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .first_err_valid(fev), .first_err_idx(fei)
   );

   gate_response_checker #(.N_IN(N_IN), .TRUTH(TRUTH), .SETTLE(SETTLE), .ERRW(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .stim(stim2), .dut_y(dut_y2),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
      .first_err_valid(fev2), .first_err_idx(fei2)
   );

   function automatic int ref_mismatches(input logic [3:0] resp, input int errmax);
      int n = 0;
      for (int i = 0; i < NV; i++) if (resp[i] !== TRUTH[i]) n++;
      return (n > errmax) ? errmax : n;
   endfunction

   function automatic int ref_first(input logic [3:0] resp);
      for (int i = 0; i < NV; i++) if (resp[i] !== TRUTH[i]) return i;
      return 0;
   endfunction

   // Called at a negedge with the checker idle or done; returns at the negedge done is seen.
   task automatic run_sweep(input logic [3:0] resp, input bit glitch, input int rp_a, input int rp_b);
      resp_cur   = resp;
      glitch_now = 1'b0;
      start      = 1'b1;
      done_at    = -1;
      @(negedge clk);
      for (int c = 1; c <= BUDGET; c++) begin
         obs_busy[c] = busy;
         obs_stim[c] = stim;
         obs_err[c]  = err_cnt;
         obs_done[c] = done;
         if (done) begin
            done_at = c;
            break;
         end
         start      = (c == rp_a) || (c == rp_b);
         glitch_now = glitch && (((c - 1) % (SETTLE + 1)) != SETTLE);
         glitch_val = 1'($urandom);
         @(negedge clk);
      end
      start      = 1'b0;
      glitch_now = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({stim, busy, done, pass, err_cnt, fev, fei} !== 15'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 0", {stim, busy, done, pass, err_cnt, fev, fei});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_and_pass();
      run_sweep(TRUTH_AND2, 1'b0, -1, -1);
      n_cmp++;
      if (done_at !== SWEEP) begin
         n_bad++;
         $display("FAIL and_done_cycle: got %0d want %0d", done_at, SWEEP);
      end
      for (int c = 1; c < SWEEP && c <= done_at; c++) begin
         n_cmp++;
         if (obs_busy[c] !== 1'b1 || obs_stim[c] !== 2'((c - 1) / (SETTLE + 1))) begin
            n_bad++;
            $display("FAIL and_seq_c%0d: got busy=%b stim=%0d want busy=1 stim=%0d",
                     c, obs_busy[c], obs_stim[c], (c - 1) / (SETTLE + 1));
         end
      end
      n_cmp++;
      if (pass !== 1'b1 || err_cnt !== 8'd0 || fev !== 1'b0 || busy !== 1'b0 || stim !== 2'd0) begin
         n_bad++;
         $display("FAIL and_result: got pass=%b err=%0d fev=%b busy=%b stim=%0d want 1 0 0 0 0",
                  pass, err_cnt, fev, busy, stim);
      end
   endtask

   task automatic test_stuck0();
      run_sweep(4'b0000, 1'b1, -1, -1);
      n_cmp++;
      if (done_at !== SWEEP || pass !== 1'b0 || err_cnt !== 8'd1 || fev !== 1'b1 || fei !== 2'd3) begin
         n_bad++;
         $display("FAIL stuck0: got done_at=%0d pass=%b err=%0d fev=%b idx=%0d want %0d 0 1 1 3",
                  done_at, pass, err_cnt, fev, fei, SWEEP);
      end
   endtask

   task automatic test_nand();
      run_sweep(TRUTH_NAND2, 1'b0, -1, -1);
      n_cmp++;
      if (done_at !== SWEEP || pass !== 1'b0 || err_cnt !== 8'd4 || fev !== 1'b1 || fei !== 2'd0) begin
         n_bad++;
         $display("FAIL nand: got done_at=%0d pass=%b err=%0d fev=%b idx=%0d want %0d 0 4 1 0",
                  done_at, pass, err_cnt, fev, fei, SWEEP);
      end
   endtask

   task automatic test_saturate();
      n_cmp++;
      if (done2 !== 1'b1 || pass2 !== 1'b0 || err2 !== 1'b1 || fev2 !== 1'b1 || fei2 !== 2'd0) begin
         n_bad++;
         $display("FAIL saturate_errw1: got done=%b pass=%b err=%0d fev=%b idx=%0d want 1 0 1 1 0",
                  done2, pass2, err2, fev2, fei2);
      end
   endtask

   task automatic test_start_ignored();
      run_sweep(4'b0000, 1'b1, 4, 9);
      n_cmp++;
      if (done_at !== SWEEP || err_cnt !== 8'd1 || fei !== 2'd3 || pass !== 1'b0) begin
         n_bad++;
         $display("FAIL start_ignored: got done_at=%0d err=%0d idx=%0d pass=%b want %0d 1 3 0",
                  done_at, err_cnt, fei, pass, SWEEP);
      end
   endtask

   task automatic test_reset_midrun();
      resp_cur = TRUTH_NAND2;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midrun_busy: got %b want 1", busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++;
      if ({stim, busy, done, pass, err_cnt, fev, fei} !== 15'd0 || {busy2, done2, err2, fev2} !== 4'd0) begin
         n_bad++;
         $display("FAIL midrun_reset: got %h sat=%h want 0 0",
                  {stim, busy, done, pass, err_cnt, fev, fei}, {busy2, done2, err2, fev2});
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL midrun_no_resume: got busy=%b done=%b want 0 0", busy, done);
      end
      run_sweep(TRUTH_AND2, 1'b1, -1, -1);
      n_cmp++;
      if (done_at !== SWEEP || pass !== 1'b1 || err_cnt !== 8'd0) begin
         n_bad++;
         $display("FAIL midrun_rerun: got done_at=%0d pass=%b err=%0d want %0d 1 0",
                  done_at, pass, err_cnt, SWEEP);
      end
   endtask

   task automatic test_restart();
      run_sweep(TRUTH_NAND2, 1'b0, -1, -1);
      run_sweep(TRUTH_AND2, 1'b0, -1, -1);
      n_cmp++;
      if (obs_err[1] !== 8'd0 || obs_done[1] !== 1'b0 || obs_busy[1] !== 1'b1) begin
         n_bad++;
         $display("FAIL restart_clear: got err=%0d done=%b busy=%b want 0 0 1",
                  obs_err[1], obs_done[1], obs_busy[1]);
      end
      n_cmp++;
      if (done_at !== SWEEP || pass !== 1'b1 || err_cnt !== 8'd0 || fev !== 1'b0) begin
         n_bad++;
         $display("FAIL restart_result: got done_at=%0d pass=%b err=%0d fev=%b want %0d 1 0 0",
                  done_at, pass, err_cnt, fev, SWEEP);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 10; it++) begin
         logic [3:0] resp;
         int         exp_err, exp_first;
         resp      = 4'($urandom_range(0, 15));
         exp_err   = ref_mismatches(resp, 255);
         exp_first = ref_first(resp);
         run_sweep(resp, 1'b1, (it % 2 == 0) ? 5 : -1, -1);
         n_cmp++;
         if (done_at !== SWEEP || int'(err_cnt) !== exp_err || pass !== (exp_err == 0)
             || fev !== (exp_err != 0) || int'(fei) !== exp_first) begin
            n_bad++;
            $display("FAIL random_%0d resp=%b: got done_at=%0d err=%0d pass=%b fev=%b idx=%0d want %0d %0d %b %b %0d",
                     it, resp, done_at, err_cnt, pass, fev, fei,
                     SWEEP, exp_err, exp_err == 0, exp_err != 0, exp_first);
         end
      end
   endtask

   initial begin
      test_reset();
      test_and_pass();
      test_saturate();
      test_stuck0();
      test_nand();
      test_start_ignored();
      test_reset_midrun();
      test_restart();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
